// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_entry_t : {pc, inst} pair held in the fetch FIFO (pc in the upper bits)
//   sat_add       : 32-bit saturating add used by the optional performance counters
package fetch_pkg;
    localparam int INST_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int INST_BYTES = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries, power-of-two DEPTH.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   push, push_data    write push_data at the tail (caller guarantees space or a same-cycle pop)
//   pop                drop the head entry (caller guarantees non-empty)
//   flush              empty the FIFO; overrides push and pop in the same cycle
//   head_data          entry at the head, zero when empty
//   count              number of valid entries (0..DEPTH)
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int ENTRY_W = ADDR_W + INST_W,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] head_data,
    output logic [CNT_W-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the PC into a combinational instruction memory, queues
// {pc, inst} in a small FIFO and hands it to decode over valid/ready.
// Redirects flush the FIFO; a misaligned or out-of-range PC raises a sticky fault.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   imem_pos / imem_read                byte address out, 32-bit word back (same cycle)
//   redirect_valid / redirect_target    branch/jump taken, new PC
//   out_valid / out_ready / out_inst / out_pc   decode handshake and payload
//   fault / fault_pc                    sticky fault and the PC that caused it
// Build option IFETCH_PERF_CNT_EN adds saturating counters
//   perf_fetched, perf_flushed, perf_stall.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH      = 2,
    parameter int          IMEM_BYTES = 64,
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pos,
    input  logic [31:0] imem_read,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
    output logic [31:0] perf_stall
`endif
);
    localparam int                CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_BYTES - INST_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;

    logic               pc_legal, fifo_full, pop, enq;
    logic               fault_set, take_redirect, flush;
    logic [CNT_W-1:0]   count;
    logic [ADDR_W+INST_W-1:0] head_data;
    fetch_entry_t       head_entry;

    assign pc_legal      = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);
    assign fifo_full     = (count == CNT_W'(DEPTH));
    assign out_valid     = (count != '0);
    assign pop           = out_valid && out_ready && !redirect_valid;
    assign enq           = !fault_q && !redirect_valid && pc_legal && (!fifo_full || pop);
    assign fault_set     = !fault_q && !pc_legal;
    // Once faulted, redirects are dropped so the fault stays terminal until reset.
    assign take_redirect = redirect_valid && !fault_q;
    assign flush         = take_redirect || fault_set;

    // An illegal PC faults even if a redirect arrives on the same edge: the
    // offending PC is the one already presented to memory.
    always_comb begin
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (fault_set) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
        end else if (take_redirect) begin
            pc_d = redirect_target;
        end else if (enq) begin
            pc_d = pc_q + ADDR_W'(INST_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (enq),
        .push_data ({pc_q, imem_read}),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_data),
        .count     (count)
    );

    assign head_entry = fetch_entry_t'(head_data);
    assign imem_pos   = pc_q;
    assign out_pc     = head_entry.pc;
    assign out_inst   = head_entry.inst;
    assign fault      = fault_q;
    assign fault_pc   = fault_pc_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Only redirects count as flushes; the fault-edge flush is not a redirect.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_flushed_d = perf_flushed_q;
        perf_stall_d   = perf_stall_q;
        if (enq)              perf_fetched_d = sat_add(perf_fetched_q, 32'd1);
        if (take_redirect)    perf_flushed_d = sat_add(perf_flushed_q, 32'(count));
        if (fifo_full && !pop) perf_stall_d  = sat_add(perf_stall_q, 32'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
    assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: byte-array big-endian memory model, a scoreboard
// of expected deliveries popped on every decode handshake, and per-scenario tasks.
module tb_instruction_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_pos, imem_read;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_inst, out_pc;
    logic        fault;
    logic [31:0] fault_pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] mem [64];

    instruction_fetch #(.DEPTH(2), .IMEM_BYTES(64), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_pos        (imem_pos),
        .imem_read       (imem_read),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .fault           (fault),
        .fault_pc        (fault_pc)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_flushed    (perf_flushed),
        .perf_stall      (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h1111_1111;
        if (a == 32'h4) return 32'h2222_2222;
        return {8'hC0, a[7:0], 8'h5A, ~a[7:0]};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            logic [31:0] w;
            w = word_at(32'(i * 4));
            mem[i*4]   = w[31:24];
            mem[i*4+1] = w[23:16];
            mem[i*4+2] = w[15:8];
            mem[i*4+3] = w[7:0];
        end
    end

    always_comb begin
        imem_read = 32'h0;
        if (imem_pos <= 32'd60)
            imem_read = {mem[int'(imem_pos)], mem[int'(imem_pos)+1],
                         mem[int'(imem_pos)+2], mem[int'(imem_pos)+3]};
    end

    // Handshake monitor: samples just before the rising edge, after inputs settled.
    always begin
        exp_t e;
        @(negedge clk);
        #3;
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL deliver_unexpected got pc=%h inst=%h required no delivery", out_pc, out_inst);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e.pc || out_inst !== e.inst) begin
                    errors++;
                    $display("FAIL deliver_order got pc=%h inst=%h required pc=%h inst=%h",
                             out_pc, out_inst, e.pc, e.inst);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic ready);
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        out_ready       = ready;
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = word_at(pc);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", out_valid); end
        checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL reset_payload got pc=%h inst=%h required 0/0", out_pc, out_inst); end
        checks++; if (imem_pos !== 32'h0) begin errors++; $display("FAIL reset_pos got %h required 0", imem_pos); end
        checks++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault got %b/%h required 0/0", fault, fault_pc); end
    endtask

    // Stream the whole memory with decode always ready, then run off the end.
    task automatic test_basic_and_end();
        apply_reset(1'b1);
        for (int i = 0; i < 16; i++) push_exp(32'(i * 4));
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h1111_1111) begin errors++; $display("FAIL first_fetch got v=%b pc=%h inst=%h required 1/0/11111111", out_valid, out_pc, out_inst); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_inst !== 32'h2222_2222) begin errors++; $display("FAIL second_fetch got v=%b pc=%h inst=%h required 1/4/22222222", out_valid, out_pc, out_inst); end
        repeat (20) step();
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h40) begin errors++; $display("FAIL end_fault got %b/%h required 1/40", fault, fault_pc); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL end_valid got %b required 0", out_valid); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL end_drained got %0d pending required 0", exp_q.size()); end
`ifdef IFETCH_PERF_CNT_EN
        checks++; if (perf_fetched !== 32'd16 || perf_stall !== 32'd0) begin errors++; $display("FAIL perf_stream got fetched=%0d stall=%0d required 16/0", perf_fetched, perf_stall); end
`endif
    endtask

    task automatic test_stall();
        apply_reset(1'b0);
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_pos !== 32'h8) begin errors++; $display("FAIL stall_hold got v=%b pc=%h pos=%h required 1/0/8", out_valid, out_pc, imem_pos); end
        end
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'(k * 4)) begin errors++; $display("FAIL stall_release got v=%b pc=%h required 1/%h", out_valid, out_pc, 32'(k * 4)); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drained got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        apply_reset(1'b0);
        repeat (2) step();
        redirect_valid  = 1'b1;
        redirect_target = 32'h20;
        out_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || imem_pos !== 32'h20) begin errors++; $display("FAIL redirect_flush got v=%b pos=%h required 0/20", out_valid, imem_pos); end
        push_exp(32'h20);
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_inst !== word_at(32'h20)) begin errors++; $display("FAIL redirect_target got v=%b pc=%h inst=%h required 1/20/%h", out_valid, out_pc, out_inst, word_at(32'h20)); end
        step();
        out_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redirect_drained got %0d pending required 0", exp_q.size()); end
`ifdef IFETCH_PERF_CNT_EN
        checks++; if (perf_flushed !== 32'd2) begin errors++; $display("FAIL perf_flushed got %0d required 2", perf_flushed); end
`endif
    endtask

    task automatic test_fault();
        redirect_valid  = 1'b1;
        redirect_target = 32'h22;
        step();
        redirect_valid = 1'b0;
        checks++; if (fault !== 1'b0 || imem_pos !== 32'h22 || out_valid !== 1'b0) begin errors++; $display("FAIL fault_pending got f=%b pos=%h v=%b required 0/22/0", fault, imem_pos, out_valid); end
        step();
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h22 || out_valid !== 1'b0) begin errors++; $display("FAIL fault_set got f=%b fpc=%h v=%b required 1/22/0", fault, fault_pc, out_valid); end
        redirect_valid  = 1'b1;
        redirect_target = 32'h10;
        out_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (fault !== 1'b1 || fault_pc !== 32'h22 || imem_pos !== 32'h22 || out_valid !== 1'b0) begin errors++; $display("FAIL fault_sticky got f=%b fpc=%h pos=%h v=%b required 1/22/22/0", fault, fault_pc, imem_pos, out_valid); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (fault !== 1'b0 || fault_pc !== 32'h0 || out_valid !== 1'b0 || imem_pos !== 32'h0) begin errors++; $display("FAIL async_fault_clear got f=%b fpc=%h v=%b pos=%h required 0/0/0/0", fault, fault_pc, out_valid, imem_pos); end
`ifdef IFETCH_PERF_CNT_EN
        checks++; if (perf_fetched !== 32'd0 || perf_flushed !== 32'd0 || perf_stall !== 32'd0) begin errors++; $display("FAIL async_perf got %0d/%0d/%0d required 0/0/0", perf_fetched, perf_flushed, perf_stall); end
`endif
        step();
        rst_n = 1'b1;
        repeat (2) step();
        checks++; if (out_valid !== 1'b1 || imem_pos !== 32'h8) begin errors++; $display("FAIL async_prefill got v=%b pos=%h required 1/8", out_valid, imem_pos); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || imem_pos !== 32'h0) begin errors++; $display("FAIL async_midstream got v=%b pc=%h inst=%h pos=%h required 0/0/0/0", out_valid, out_pc, out_inst, imem_pos); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_and_end();
        test_stall();
        test_redirect();
        test_fault();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
